// File: rtl/alm_log_div.sv
`default_nettype none
// ============================================================================
// Module  : alm_log_div
// Brief   : Three-stage Mitchell log-domain approximate divider, 32b / 16b ->
//           16b saturated quotient, valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module alm_log_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] n,
  input  logic [15:0] d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        sat,
  output logic        dz
);

  localparam logic [15:0] c_q_max = 16'hFFFF;

  // Stage valid bits and load enables; each stage loads when empty or draining.
  logic r_v1, r_v2, r_v3;
  logic w_en1, w_en2, w_en3;

  assign w_en3    = !r_v3 || out_ready;
  assign w_en2    = !r_v2 || w_en3;
  assign w_en1    = !r_v1 || w_en2;
  assign in_ready = w_en1;

  // ---------------- S1: leading-one detect / normalize ----------------
  logic [4:0]  w_kn;
  logic [3:0]  w_kd;
  logic [14:0] w_fn, w_fd;

  always_comb begin
    w_kn = '0;
    for (int i = 0; i < 32; i++) begin
      if (n[i]) w_kn = 5'(i);
    end
    w_kd = '0;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) w_kd = 4'(i);
    end
  end

  assign w_fn = 15'((n << (5'd31 - w_kn)) >> 16);
  assign w_fd = 15'(d << (4'd15 - w_kd));

  logic [4:0]  r_kn1;
  logic [3:0]  r_kd1;
  logic [14:0] r_fn1, r_fd1;
  logic        r_zn1, r_zd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_kn1 <= '0;
      r_kd1 <= '0;
      r_fn1 <= '0;
      r_fd1 <= '0;
      r_zn1 <= 1'b0;
      r_zd1 <= 1'b0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_kn1 <= w_kn;
        r_kd1 <= w_kd;
        r_fn1 <= w_fn;
        r_fd1 <= w_fd;
        r_zn1 <= (n == 32'd0);
        r_zd1 <= (d == 16'd0);
      end
    end
  end

  // ---------------- S2: log subtract ----------------
  // A borrow out of the fraction subtract moves one unit into the exponent;
  // the low 15 bits of the difference are already the wrapped fraction.
  logic [15:0]       w_diff;
  logic signed [5:0] w_e;

  assign w_diff = {1'b0, r_fn1} - {1'b0, r_fd1};
  assign w_e    = 6'({1'b0, r_kn1}) - 6'({2'b00, r_kd1}) - 6'(w_diff[15]);

  logic signed [5:0] r_e2;
  logic [14:0]       r_df2;
  logic              r_zn2, r_zd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_e2  <= '0;
      r_df2 <= '0;
      r_zn2 <= 1'b0;
      r_zd2 <= 1'b0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_e2  <= w_e;
        r_df2 <= w_diff[14:0];
        r_zn2 <= r_zn1;
        r_zd2 <= r_zd1;
      end
    end
  end

  // ---------------- S3: antilog, registered outputs ----------------
  logic [15:0] w_m;
  logic [15:0] w_q;
  logic        w_sat, w_dz;

  assign w_m = {1'b1, r_df2};

  always_comb begin
    w_q   = '0;
    w_sat = 1'b0;
    w_dz  = 1'b0;
    if (r_zd2) begin
      w_q  = c_q_max;
      w_dz = 1'b1;
    end else if (r_zn2) begin
      w_q = '0;
    end else if (r_e2 > 6'sd15) begin
      w_q   = c_q_max;
      w_sat = 1'b1;
    end else if (r_e2 < 6'sd0) begin
      w_q = '0;
    end else begin
      w_q = w_m >> (4'd15 - r_e2[3:0]);
    end
  end

  logic        r_v3_q;
  logic [15:0] r_q;
  logic        r_sat, r_dz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3  <= 1'b0;
      r_q   <= '0;
      r_sat <= 1'b0;
      r_dz  <= 1'b0;
    end else if (w_en3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_q   <= w_q;
        r_sat <= w_sat;
        r_dz  <= w_dz;
      end
    end
  end

  assign r_v3_q    = r_v3;
  assign out_valid = r_v3_q;
  assign q         = r_q;
  assign sat       = r_sat;
  assign dz        = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_alm_log_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_alm_log_div
// Brief   : Vector table plus scoreboard bench for alm_log_div.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alm_log_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        sat;
  logic        dz;

  always #5 clk = ~clk;

  alm_log_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .sat       (sat),
    .dz        (dz)
  );

  typedef struct {
    logic [31:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic        sat;
    logic        dz;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole log value as one fixed-point integer, split after subtract.
  function automatic logic [17:0] model(input logic [31:0] nn, input logic [15:0] dd);
    int     kn, kd;
    longint ln, ld, tot, e, df, qq;
    if (dd == 0) return {16'hFFFF, 1'b0, 1'b1};
    if (nn == 0) return 18'd0;
    kn = 0;
    kd = 0;
    for (int i = 0; i < 32; i++) if (nn[i]) kn = i;
    for (int i = 0; i < 16; i++) if (dd[i]) kd = i;
    ln  = longint'(kn) * 32768 + ((longint'(nn) - (longint'(1) << kn)) * 32768) / (longint'(1) << kn);
    ld  = longint'(kd) * 32768 + ((longint'(dd) - (longint'(1) << kd)) * 32768) / (longint'(1) << kd);
    tot = ln - ld;
    e   = tot >>> 15;
    df  = tot & 32767;
    if (e > 15) return {16'hFFFF, 1'b1, 1'b0};
    if (e < 0) return 18'd0;
    qq = ((32768 + df) << e) >> 15;
    return {16'(qq), 1'b0, 1'b0};
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] nn, input logic [15:0] dd, input logic [17:0] ex);
    bit acc = 1'b0;
    n        = nn;
    d        = dd;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) sb.push_back(ex);
    else chk("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() > 0; c++) @(posedge clk);
    #1;
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [17:0] ex;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        ex = sb.pop_front();
        chk("q", {16'd0, q}, {16'd0, ex[17:2]});
        chk("sat", {31'd0, sat}, {31'd0, ex[1]});
        chk("dz", {31'd0, dz}, {31'd0, ex[0]});
      end
    end
  end

  vec_t        tbl[12];
  logic [31:0] bp_n[6];
  logic [15:0] bp_d[6];

  initial begin
    logic [15:0] h_q;
    logic        h_sat, h_dz;
    int          accepted;
    bit          acc;

    tbl[0]  = '{32'd100,        16'd10,     16'd10,     1'b0, 1'b0};
    tbl[1]  = '{32'd1000,       16'd3,      16'd372,    1'b0, 1'b0};
    tbl[2]  = '{32'd6,          16'd8,      16'd0,      1'b0, 1'b0};
    tbl[3]  = '{32'h4000_0000,  16'h8000,   16'h8000,   1'b0, 1'b0};
    tbl[4]  = '{32'h0010_0000,  16'd1,      16'hFFFF,   1'b1, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFF,  16'hFFFF,   16'hFFFF,   1'b1, 1'b0};
    tbl[6]  = '{32'd0,          16'd0,      16'hFFFF,   1'b0, 1'b1};
    tbl[7]  = '{32'd5,          16'd0,      16'hFFFF,   1'b0, 1'b1};
    tbl[8]  = '{32'd0,          16'd7,      16'd0,      1'b0, 1'b0};
    tbl[9]  = '{32'd1,          16'd1,      16'd1,      1'b0, 1'b0};
    tbl[10] = '{32'd65535,      16'd1,      16'hFFFF,   1'b0, 1'b0};
    tbl[11] = '{32'd65536,      16'd1,      16'hFFFF,   1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      bp_n[i] = $urandom >> $urandom_range(0, 16);
      bp_d[i] = 16'($urandom_range(1, 65535));
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = '0;
    d         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_q", {16'd0, q}, 32'd0);
    chk("reset_flags", {30'd0, sat, dz}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: capture edge then two more edges.
    @(posedge clk);
    #1;
    send(32'd100, 16'd10, {16'd10, 1'b0, 1'b0});
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("latency_edge2_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency_edge3_out_valid", {31'd0, out_valid}, 32'd1);
    drain();

    for (int i = 0; i < 12; i++)
      send(tbl[i].n, tbl[i].d, {tbl[i].q, tbl[i].sat, tbl[i].dz});
    in_valid = 1'b0;
    drain();

    // Backpressure: consumer stalled for five cycles while six pairs wait.
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 5; c++) begin
      n        = bp_n[accepted];
      d        = bp_d[accepted];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back(model(bp_n[accepted], bp_d[accepted]));
        accepted++;
      end
    end
    chk("bp_accepts_while_stalled", accepted, 32'd3);
    chk("bp_in_ready_dropped", {31'd0, in_ready}, 32'd0);
    h_q   = q;
    h_sat = sat;
    h_dz  = dz;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_q", {16'd0, q}, {16'd0, h_q});
      chk("bp_hold_flags", {30'd0, sat, dz}, {30'd0, h_sat, h_dz});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j < 3) begin
        n        = bp_n[3 + j];
        d        = bp_d[3 + j];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_stream_out_valid", {31'd0, out_valid}, 32'd1);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (j < 3) begin
        if (acc) sb.push_back(model(bp_n[3 + j], bp_d[3 + j]));
        else chk("bp_release_in_ready", {31'd0, acc}, 32'd1);
      end
    end
    in_valid = 1'b0;
    drain();

    // Reset with three results in flight.
    send(32'd12345, 16'd17, model(32'd12345, 16'd17));
    send(32'd777,   16'd9,  model(32'd777, 16'd9));
    send(32'd40000, 16'd3,  model(32'd40000, 16'd3));
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_q", {16'd0, q}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flushed_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'd1000, 16'd3, {16'd372, 1'b0, 1'b0});
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
